// File: rtl/wb_host_resp.sv
// Wishbone classic slave that forwards each bus access to an external host over a
// request/response handshake, with timeout and illegal-select termination.
module wb_host_resp #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_SEL_WIDTH = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter logic [WB_DATA_WIDTH-1:0] ERR_DATA = WB_DATA_WIDTH'(32'hDEAD_BEEF)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
    input  logic                     wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_cyc_i,
    output logic                     wb_ack_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    output logic                     host_req_valid_o,
    output logic [WB_ADDR_WIDTH-1:0] host_req_addr_o,
    output logic [WB_DATA_WIDTH-1:0] host_req_data_o,
    output logic [1:0]               host_req_size_o,
    output logic                     host_req_we_o,
    input  logic                     host_req_taken_i,
    input  logic                     host_resp_valid_i,
    input  logic [WB_DATA_WIDTH-1:0] host_resp_data_i,
    output logic                     timeout_o,
    output logic                     sel_err_o,
    input  logic                     status_clear_i,
    output logic [2:0]               dbg_state
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic TO_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ACK, S_DRAIN} state_t;

    state_t                   state, state_nx;
    logic [CNT_W-1:0]         cnt, cnt_nx;
    logic [WB_DATA_WIDTH-1:0] rdata_nx;
    logic [WB_DATA_WIDTH-1:0] resp_fmt;
    logic [1:0]               size_dec;
    logic                     sel_ok;
    logic                     latch_en;
    logic                     to_set;
    logic                     sel_set;
    logic                     to_hit;
    logic                     bus_req;

    assign dbg_state = state;
    assign bus_req   = wb_cyc_i && wb_stb_i;
    assign to_hit    = TO_EN && (cnt == TO_LAST);

    always_comb begin
        sel_ok   = 1'b1;
        size_dec = 2'd0;
        if (wb_sel_i == WB_SEL_WIDTH'(4'b0001))      size_dec = 2'd0;
        else if (wb_sel_i == WB_SEL_WIDTH'(4'b0011)) size_dec = 2'd1;
        else if (wb_sel_i == WB_SEL_WIDTH'(4'b1111)) size_dec = 2'd2;
        else                                         sel_ok   = 1'b0;
    end

    // Read data is shaped by the size latched at request time, not the live select.
    always_comb begin
        resp_fmt = '0;
        if (!host_req_we_o) begin
            case (host_req_size_o)
                2'd0:    resp_fmt = WB_DATA_WIDTH'(host_resp_data_i[7:0]);
                2'd1:    resp_fmt = WB_DATA_WIDTH'(host_resp_data_i[15:0]);
                default: resp_fmt = host_resp_data_i;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rdata_nx = wb_data_o;
        latch_en = 1'b0;
        to_set   = 1'b0;
        sel_set  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus_req) begin
                    latch_en = 1'b1;
                    if (sel_ok) begin
                        state_nx = S_REQ;
                        cnt_nx   = '0;
                    end else begin
                        state_nx = S_ACK;
                        rdata_nx = ERR_DATA;
                        sel_set  = 1'b1;
                    end
                end
            end
            S_REQ: begin
                cnt_nx = cnt + CNT_W'(1);
                if (!wb_cyc_i) begin
                    state_nx = S_IDLE;
                end else if (host_req_taken_i && host_resp_valid_i) begin
                    state_nx = S_ACK;
                    rdata_nx = resp_fmt;
                end else if (to_hit) begin
                    state_nx = S_ACK;
                    rdata_nx = ERR_DATA;
                    to_set   = 1'b1;
                end else if (host_req_taken_i) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_nx = cnt + CNT_W'(1);
                if (host_resp_valid_i) begin
                    state_nx = wb_cyc_i ? S_ACK : S_IDLE;
                    if (wb_cyc_i) rdata_nx = resp_fmt;
                end else if (!wb_cyc_i) begin
                    state_nx = S_DRAIN;
                end else if (to_hit) begin
                    state_nx = S_ACK;
                    rdata_nx = ERR_DATA;
                    to_set   = 1'b1;
                end
            end
            S_ACK: begin
                state_nx = S_IDLE;
            end
            S_DRAIN: begin
                cnt_nx = cnt + CNT_W'(1);
                if (host_resp_valid_i) begin
                    state_nx = S_IDLE;
                end else if (to_hit) begin
                    state_nx = S_IDLE;
                    to_set   = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state            <= S_IDLE;
            cnt              <= '0;
            wb_ack_o         <= 1'b0;
            wb_data_o        <= '0;
            host_req_valid_o <= 1'b0;
            host_req_addr_o  <= '0;
            host_req_data_o  <= '0;
            host_req_size_o  <= 2'd0;
            host_req_we_o    <= 1'b0;
            timeout_o        <= 1'b0;
            sel_err_o        <= 1'b0;
        end else begin
            state            <= state_nx;
            cnt              <= cnt_nx;
            wb_ack_o         <= (state_nx == S_ACK);
            wb_data_o        <= rdata_nx;
            host_req_valid_o <= (state_nx == S_REQ);
            if (latch_en) begin
                host_req_addr_o <= wb_addr_i;
                host_req_data_o <= wb_data_i;
                host_req_size_o <= size_dec;
                host_req_we_o   <= wb_we_i;
            end
            // A flag being set outranks a clear arriving in the same cycle.
            if (to_set)              timeout_o <= 1'b1;
            else if (status_clear_i) timeout_o <= 1'b0;
            if (sel_set)             sel_err_o <= 1'b1;
            else if (status_clear_i) sel_err_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_host_resp.sv
// Directed bench for wb_host_resp: a per-transaction outcome model schedules the
// expected ack edge, read data, request window and flags; one process compares each cycle.
module tb_wb_host_resp;

    localparam int N   = 16;
    localparam int INF = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wb_addr = '0;
    logic [31:0] wb_wdata = '0;
    logic        wb_we = 1'b0;
    logic [3:0]  wb_sel = '0;
    logic        wb_stb = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_ack;
    logic [31:0] wb_rdata;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        req_we;
    logic        taken = 1'b0;
    logic        resp = 1'b0;
    logic [31:0] resp_data = '0;
    logic        timeout_flag;
    logic        sel_err_flag;
    logic        status_clear = 1'b0;
    logic [2:0]  dbg_state;

    wb_host_resp #(.TIMEOUT_CYCLES(N)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .wb_addr_i(wb_addr), .wb_data_i(wb_wdata), .wb_we_i(wb_we), .wb_sel_i(wb_sel),
        .wb_stb_i(wb_stb), .wb_cyc_i(wb_cyc), .wb_ack_o(wb_ack), .wb_data_o(wb_rdata),
        .host_req_valid_o(req_valid), .host_req_addr_o(req_addr), .host_req_data_o(req_data),
        .host_req_size_o(req_size), .host_req_we_o(req_we), .host_req_taken_i(taken),
        .host_resp_valid_i(resp), .host_resp_data_i(resp_data), .timeout_o(timeout_flag),
        .sel_err_o(sel_err_flag), .status_clear_i(status_clear), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n++;

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    int          edge_q[$];
    int sch_vlo = -1, sch_vhi = -2, sch_to = -1, sch_se = -1, sch_clr = -1;
    logic [31:0] exp_addr = '0, exp_wdata = '0, exp_rd = '0;
    logic [1:0]  exp_size = '0;
    logic        exp_we = 1'b0, exp_to = 1'b0, exp_se = 1'b0;
    logic [31:0] last_ack_data = '0;
    int          last_ack_edge = -1;
    int          ack_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %h want %h", name, edge_n, act, exp);
        end
    endtask

    // Outcome of one access from the handshake rules. Offsets are edges after the
    // strobe edge k; -1 means the event never happens.
    task automatic predict(input logic legal, input logic we, input logic [1:0] size,
                           input int t, input int r, input int a, input logic [31:0] rd,
                           output int ack_d, output logic [31:0] data,
                           output int to_d, output int vhi);
        int tt, rr, aa, d1, rw, d2, rdr;
        logic [31:0] norm;
        ack_d = -1; to_d = -1; vhi = -1; data = '0;
        norm = we ? 32'h0 : (size == 2'd0) ? {24'h0, rd[7:0]} :
               (size == 2'd1) ? {16'h0, rd[15:0]} : rd;
        if (!legal) begin
            ack_d = 0;
            data  = 32'hDEAD_BEEF;
            return;
        end
        tt = (t < 0) ? INF : t;
        rr = (r < 0) ? INF : r;
        aa = (a < 0) ? INF : a;
        d1 = (tt < aa) ? tt : aa;
        if (N < d1) d1 = N;
        vhi = d1 - 1;
        if (aa == d1) return;
        if (tt == d1 && rr == tt) begin
            ack_d = d1; data = norm;
        end else if (d1 == N) begin
            ack_d = N; data = 32'hDEAD_BEEF; to_d = N;
        end else begin
            rw = (rr > tt) ? rr : INF;
            d2 = (rw < aa) ? rw : aa;
            if (N < d2) d2 = N;
            if (rw == d2) begin
                if (aa != rw) begin ack_d = rw; data = norm; end
            end else if (aa == d2) begin
                rdr = (rr > aa) ? rr : INF;
                if (N < rdr) to_d = N;
            end else begin
                ack_d = N; data = 32'hDEAD_BEEF; to_d = N;
            end
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic exp_valid;
        if (!rst_n) begin
            exp_to = 1'b0;
            exp_se = 1'b0;
            exp_rd = '0;
            chk("rst_ack", {31'h0, wb_ack}, 32'h0);
            chk("rst_valid", {31'h0, req_valid}, 32'h0);
            chk("rst_rdata", wb_rdata, 32'h0);
        end else begin
            if (sch_to == edge_n)       exp_to = 1'b1;
            else if (sch_clr == edge_n) exp_to = 1'b0;
            if (sch_se == edge_n)       exp_se = 1'b1;
            else if (sch_clr == edge_n) exp_se = 1'b0;
            exp_valid = (edge_n >= sch_vlo) && (edge_n <= sch_vhi);
            chk("req_valid", {31'h0, req_valid}, {31'h0, exp_valid});
            if (exp_valid) begin
                chk("req_addr", req_addr, exp_addr);
                chk("req_data", req_data, exp_wdata);
                chk("req_size", {30'h0, req_size}, {30'h0, exp_size});
                chk("req_we", {31'h0, req_we}, {31'h0, exp_we});
            end
            if (wb_ack) begin
                ack_cnt++;
                last_ack_data = wb_rdata;
                last_ack_edge = edge_n;
                total++;
                if (edge_q.size() > 0 && edge_q[0] == edge_n) begin
                    void'(edge_q.pop_front());
                    exp_rd = exp_q.pop_front();
                end else begin
                    bad++;
                    $display("FAIL ack_timing at edge %0d: got ack want none", edge_n);
                end
            end else if (edge_q.size() > 0 && edge_q[0] <= edge_n) begin
                total++;
                bad++;
                $display("FAIL ack_missing at edge %0d: got none want ack at %0d", edge_n, edge_q[0]);
                void'(edge_q.pop_front());
                exp_rd = exp_q.pop_front();
            end
            chk("rdata", wb_rdata, exp_rd);
            chk("timeout_o", {31'h0, timeout_flag}, {31'h0, exp_to});
            chk("sel_err_o", {31'h0, sel_err_flag}, {31'h0, exp_se});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                           input logic [3:0] sel, input int t, input int r, input int a,
                           input logic [31:0] rd, output int k);
        logic legal;
        logic [1:0] size;
        logic [31:0] d;
        int ack_d, to_d, vhi;
        legal = (sel == 4'b0001) || (sel == 4'b0011) || (sel == 4'b1111);
        size  = (sel == 4'b0011) ? 2'd1 : (sel == 4'b1111) ? 2'd2 : 2'd0;
        predict(legal, we, size, t, r, a, rd, ack_d, d, to_d, vhi);
        @(posedge clk); #1;
        k = edge_n + 1;
        if (ack_d >= 0) begin
            exp_q.push_back(d);
            edge_q.push_back(k + ack_d);
        end
        exp_addr = addr; exp_wdata = wdata; exp_we = we; exp_size = size;
        sch_vlo = k;
        sch_vhi = (vhi >= 0) ? k + vhi : -2;
        sch_to  = (to_d >= 0) ? k + to_d : -1;
        sch_se  = legal ? -1 : k;
        wb_addr = addr; wb_wdata = wdata; wb_we = we; wb_sel = sel;
        wb_cyc = 1'b1; wb_stb = 1'b1; resp_data = rd;
        for (int dd = 1; dd < 20; dd++) begin
            @(posedge clk); #1;
            taken  = (dd == t);
            resp   = (dd == r);
            wb_cyc = (a < 0 || dd < a) && (ack_d < 0 || dd <= ack_d);
            wb_stb = wb_cyc;
        end
        @(posedge clk); #1;
        taken = 1'b0; resp = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    task automatic clear_flags();
        @(posedge clk); #1;
        status_clear = 1'b1;
        sch_clr = edge_n + 1;
        @(posedge clk); #1;
        status_clear = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int k, n0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack", {31'h0, wb_ack}, 32'h0);
        chk("reset_rdata", wb_rdata, 32'h0);
        chk("reset_valid", {31'h0, req_valid}, 32'h0);
        chk("reset_addr", req_addr, 32'h0);
        chk("reset_flags", {30'h0, timeout_flag, sel_err_flag}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // word read, response two cycles after the take
        n0 = ack_cnt;
        run_txn(32'h8000_0010, 32'h0, 1'b0, 4'b1111, 1, 3, -1, 32'h1234_5678, k);
        chk("word_rd_acks", ack_cnt - n0, 1);
        chk("word_rd_lat", last_ack_edge - k, 3);
        chk("word_rd_data", last_ack_data, 32'h1234_5678);

        // byte write, zero-wait host: minimum latency
        n0 = ack_cnt;
        run_txn(32'h8000_0020, 32'hAABB_CCDD, 1'b1, 4'b0001, 1, 1, -1, 32'h5555_5555, k);
        chk("byte_wr_lat", last_ack_edge - k, 1);
        chk("byte_wr_data", last_ack_data, 32'h0);
        chk("byte_wr_acks", ack_cnt - n0, 1);

        // byte and half reads
        run_txn(32'h8000_0030, 32'h0, 1'b0, 4'b0001, 1, 1, -1, 32'hFFFF_FF5A, k);
        chk("byte_rd_data", last_ack_data, 32'h0000_005A);
        run_txn(32'h8000_0032, 32'h0, 1'b0, 4'b0011, 2, 4, -1, 32'hFFFF_FF5A, k);
        chk("half_rd_data", last_ack_data, 32'h0000_FF5A);
        chk("half_rd_lat", last_ack_edge - k, 4);

        // silent host: timeout
        run_txn(32'h8000_0040, 32'h0, 1'b0, 4'b1111, -1, -1, -1, 32'h0, k);
        chk("to_lat", last_ack_edge - k, 16);
        chk("to_data", last_ack_data, 32'hDEAD_BEEF);
        chk("to_flag", {31'h0, timeout_flag}, 32'h1);
        clear_flags();
        chk("to_cleared", {31'h0, timeout_flag}, 32'h0);

        // response on the final cycle wins over the timeout
        run_txn(32'h8000_0044, 32'h0, 1'b0, 4'b1111, 1, 16, -1, 32'hCAFE_F00D, k);
        chk("late_resp_lat", last_ack_edge - k, 16);
        chk("late_resp_data", last_ack_data, 32'hCAFE_F00D);
        chk("late_resp_flag", {31'h0, timeout_flag}, 32'h0);

        // response before the take is ignored, so the access times out
        run_txn(32'h8000_0048, 32'h0, 1'b0, 4'b1111, 4, 2, -1, 32'h1111_2222, k);
        chk("early_resp_data", last_ack_data, 32'hDEAD_BEEF);
        clear_flags();

        // illegal select
        n0 = ack_cnt;
        run_txn(32'h8000_0050, 32'h0, 1'b0, 4'b0110, -1, -1, -1, 32'h0, k);
        chk("bad_sel_lat", last_ack_edge - k, 0);
        chk("bad_sel_data", last_ack_data, 32'hDEAD_BEEF);
        chk("bad_sel_flag", {31'h0, sel_err_flag}, 32'h1);
        chk("bad_sel_acks", ack_cnt - n0, 1);
        clear_flags();

        // cycle dropped in WAIT, late response drained, then a normal read
        n0 = ack_cnt;
        run_txn(32'h8000_0060, 32'h0, 1'b0, 4'b1111, 1, 5, 3, 32'h9999_9999, k);
        chk("drain_acks", ack_cnt - n0, 0);
        run_txn(32'h8000_0064, 32'h0, 1'b0, 4'b1111, 2, 2, -1, 32'h0BAD_F00D, k);
        chk("after_drain_data", last_ack_data, 32'h0BAD_F00D);

        // cycle dropped in REQ
        n0 = ack_cnt;
        run_txn(32'h8000_0068, 32'h0, 1'b0, 4'b1111, -1, -1, 2, 32'h0, k);
        chk("req_abort_acks", ack_cnt - n0, 0);

        // reset asserted while waiting for the host
        n0 = ack_cnt;
        @(posedge clk); #1;
        k = edge_n + 1;
        exp_addr = 32'h8000_0070; exp_wdata = 32'h0; exp_we = 1'b0; exp_size = 2'd2;
        sch_vlo = k; sch_vhi = k;
        wb_addr = 32'h8000_0070; wb_wdata = 32'h0; wb_we = 1'b0; wb_sel = 4'b1111;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        @(posedge clk); #1;
        taken = 1'b1;
        @(posedge clk); #1;
        taken = 1'b0;
        #2;
        rst_n = 1'b0;
        sch_vhi = -2;
        #1;
        chk("midrst_valid", {31'h0, req_valid}, 32'h0);
        chk("midrst_ack", {31'h0, wb_ack}, 32'h0);
        chk("midrst_addr", req_addr, 32'h0);
        chk("midrst_rdata", wb_rdata, 32'h0);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        resp = 1'b1;
        @(posedge clk); #1;
        resp = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_no_ack", ack_cnt - n0, 0);

        run_txn(32'h8000_0080, 32'h0, 1'b0, 4'b1111, 1, 2, -1, 32'h7654_3210, k);
        chk("recover_data", last_ack_data, 32'h7654_3210);

        repeat (3) @(posedge clk);
        #1;
        total++;
        if (edge_q.size() != 0) begin
            bad++;
            $display("FAIL pending_acks: got %0d outstanding want 0", edge_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
